// File: rtl/checksum_pkg.sv
// -----------------------------------------------------------------------------
// checksum_pkg
// Shared definitions for the Internet checksum engine: FSM state encoding,
// checksum and accumulator widths, and the 16-bit one's-complement fold.
// No ports (package).
// -----------------------------------------------------------------------------
package checksum_pkg;

   localparam int CSUM_W = 16;
   localparam int ACC_W  = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_FOLD  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // Two-step end-around fold of the 32-bit accumulator down to 16 bits.
   // The second add cannot carry out: f[15:0] is at most 0xFFFE when f[16] is set.
   function automatic logic [CSUM_W-1:0] fold16(input logic [ACC_W-1:0] acc);
      logic [CSUM_W:0] f;
      f = {1'b0, acc[CSUM_W-1:0]} + {1'b0, acc[ACC_W-1:CSUM_W]};
      return f[CSUM_W-1:0] + {{(CSUM_W-1){1'b0}}, f[CSUM_W]};
   endfunction

endpackage

// File: rtl/checksum_lane_sum.sv
// -----------------------------------------------------------------------------
// checksum_lane_sum
// Combinational: masks disabled bytes of a beat to 0x00 and adds the beat's
// big-endian 16-bit lanes together.
// Ports:
//   data     in  DATA_W  beat data, byte 0 in the most significant byte
//   keep     in  KEEP_W  byte enables; keep[k] qualifies data[8k+7:8k]
//   last     in  1       final beat; enables are only honoured on this beat
//   lane_sum out ACC_W   sum of the DATA_W/16 masked lanes
// -----------------------------------------------------------------------------
module checksum_lane_sum
   import checksum_pkg::*;
#(
   parameter  int DATA_W = 32,
   localparam int KEEP_W = DATA_W / 8
) (
   input  logic [DATA_W-1:0] data,
   input  logic [KEEP_W-1:0] keep,
   input  logic              last,
   output logic [ACC_W-1:0]  lane_sum
);

   localparam int LANES = DATA_W / 16;

   logic [DATA_W-1:0] masked;

   // Non-last beats are always full, so enables only matter when last is set.
   always_comb begin
      masked   = '0;
      lane_sum = '0;
      for (int k = 0; k < KEEP_W; k++) begin
         masked[8*k +: 8] = (keep[k] || !last) ? data[8*k +: 8] : 8'h00;
      end
      for (int l = 0; l < LANES; l++) begin
         lane_sum = lane_sum + {{(ACC_W-16){1'b0}}, masked[16*l +: 16]};
      end
   end

endmodule

// File: rtl/checksum_engine.sv
// -----------------------------------------------------------------------------
// checksum_engine
// Streams packet beats in, accumulates the one's-complement sum of 16-bit
// words, and presents the Internet checksum with a valid/ready handshake.
// Optional feature: define CHECKSUM_SEED_EN to add the i_seed port, whose
// value is folded into the sum on the first beat of every packet.
// Ports:
//   i_clk       in   1       clock, rising edge
//   i_rst       in   1       synchronous active-high reset
//   i_clear     in   1       synchronous abort, drops any partial/pending result
//   i_valid     in   1       input beat valid
//   o_ready     out  1       beat accepted when i_valid && o_ready
//   i_data      in   DATA_W  packet data, network byte order
//   i_keep      in   KEEP_W  byte enables (MSB = byte 0), last beat only
//   i_last      in   1       final beat of packet
//   i_seed      in   16      initial partial sum (CHECKSUM_SEED_EN only)
//   o_valid     out  1       checksum valid
//   i_ready     in   1       checksum consumed when o_valid && i_ready
//   o_checksum  out  16      one's-complement checksum
// -----------------------------------------------------------------------------
module checksum_engine
   import checksum_pkg::*;
#(
   parameter  int DATA_W = 32,
   localparam int KEEP_W = DATA_W / 8
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_clear,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic [DATA_W-1:0] i_data,
   input  logic [KEEP_W-1:0] i_keep,
   input  logic              i_last,
`ifdef CHECKSUM_SEED_EN
   input  logic [CSUM_W-1:0] i_seed,
`endif
   output logic              o_valid,
   input  logic              i_ready,
   output logic [CSUM_W-1:0] o_checksum
);

   state_t            state_q, state_d;
   logic [ACC_W-1:0]  acc_q, acc_d;
   logic [CSUM_W-1:0] csum_q, csum_d;
   logic [ACC_W-1:0]  lane_sum;
   logic [CSUM_W-1:0] seed_val;
   logic              beat_accept;

`ifdef CHECKSUM_SEED_EN
   assign seed_val = i_seed;
`else
   assign seed_val = '0;
`endif

   checksum_lane_sum #(
      .DATA_W (DATA_W)
   ) u_lane_sum (
      .data     (i_data),
      .keep     (i_keep),
      .last     (i_last),
      .lane_sum (lane_sum)
   );

   assign o_ready     = (state_q == ST_IDLE) || (state_q == ST_ACCUM);
   assign o_valid     = (state_q == ST_DONE);
   assign o_checksum  = csum_q;
   assign beat_accept = i_valid && o_ready;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= ST_IDLE;
         acc_q   <= '0;
         csum_q  <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         csum_q  <= csum_d;
      end
   end

   // Each beat folds the accumulator's upper half back in, so acc stays well
   // below 2^32 regardless of packet length.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      csum_d  = csum_q;
      case (state_q)
         ST_IDLE: begin
            if (beat_accept) begin
               acc_d   = {{(ACC_W-CSUM_W){1'b0}}, seed_val} + lane_sum;
               state_d = i_last ? ST_FOLD : ST_ACCUM;
            end
         end
         ST_ACCUM: begin
            if (beat_accept) begin
               acc_d = {{(ACC_W-CSUM_W){1'b0}}, acc_q[CSUM_W-1:0]}
                     + {{(ACC_W-CSUM_W){1'b0}}, acc_q[ACC_W-1:CSUM_W]}
                     + lane_sum;
               if (i_last) begin
                  state_d = ST_FOLD;
               end
            end
         end
         ST_FOLD: begin
            csum_d  = ~fold16(acc_q);
            state_d = ST_DONE;
         end
         ST_DONE: begin
            if (i_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      // Abort wins over any beat or result handshake in the same cycle.
      if (i_clear) begin
         state_d = ST_IDLE;
         acc_d   = '0;
      end
   end

endmodule

// File: doc/checksum_engine.md
CHECKSUM_ENGINE -- requirements
Module: checksum_engine

Interface
REQ-001 Parameter DATA_W, default 32, beat width in bits; SHALL be a multiple of 16 in 32..128.
REQ-002 Parameter KEEP_W, default DATA_W/8, byte-enable width; derived only, not overridden.
REQ-003 i_clk  input  1  single clock; all logic on rising edge.
REQ-004 i_rst  input  1  reset, synchronous, active-high.
REQ-005 i_clear  input  1  synchronous abort; returns block to IDLE and drops any partial or pending result.
REQ-006 i_valid  input  1  input beat valid.
REQ-007 o_ready  output  1  block accepts beat when i_valid && o_ready.
REQ-008 i_data  input  DATA_W  packet data, network byte order; byte 0 = i_data[DATA_W-1 -: 8].
REQ-009 i_keep  input  KEEP_W  byte enables, MSB = byte 0; all ones except on last beat.
REQ-010 i_last  input  1  marks final beat of packet.
REQ-011 o_valid  output  1  result valid.
REQ-012 i_ready  input  1  result consumed when o_valid && i_ready.
REQ-013 o_checksum  output  16  one's-complement Internet checksum of packet.

Function
REQ-014 States: IDLE, ACCUM, FOLD, DONE; encoding from shared package.
REQ-015 o_ready SHALL be 1 in IDLE and ACCUM, 0 in FOLD and DONE.
REQ-016 Per accepted beat, bytes with i_keep bit 0 SHALL be treated as 0x00; beat split into DATA_W/16 big-endian 16-bit lanes, lane_sum = sum of lanes.
REQ-017 Accumulator acc is 32 bits; per accepted beat acc_next = acc[15:0] + acc[31:16] + lane_sum (end-around carry each beat, no overflow for any packet length).
REQ-018 Beat accepted in IDLE SHALL load acc from 0 (plus seed, see Configuration) plus its lane_sum; transition to ACCUM, or FOLD if i_last.
REQ-019 ACCUM: accepted beat with i_last -> FOLD; otherwise stay.
REQ-020 FOLD (one cycle): compute f = acc[15:0] + acc[31:16], then f[15:0] + f[16]; register o_checksum = ~result; -> DONE.
REQ-021 Latency: last beat accepted cycle N -> o_valid = 1 at cycle N+2.
REQ-022 DONE: o_valid = 1, o_checksum stable until i_ready; on handshake -> IDLE, o_valid = 0 next cycle.
REQ-023 Result 0x0000 SHALL be output as is (no 0xFFFF substitution).
REQ-024 i_clear has priority over any handshake in the same cycle; beat presented with i_clear SHALL be discarded.
REQ-025 Single-beat packet (first beat has i_last) SHALL be valid.
REQ-026 i_keep SHALL be ignored (treated all ones) on non-last beats.

Reset
REQ-027 i_rst SHALL force IDLE, acc = 0, o_valid = 0, o_checksum = 0x0000, o_ready = 1 on the next edge.
REQ-028 Reset mid-packet or in DONE SHALL discard state without emitting a result.

Configuration
REQ-029 Macro CHECKSUM_SEED_EN: when defined, adds port i_seed input 16 (initial partial sum, e.g. pseudo-header); added into acc on first accepted beat of each packet.
REQ-030 Without CHECKSUM_SEED_EN: no i_seed port; initial acc is 0.

Structure
REQ-031 Package checksum_pkg SHALL hold the state enum, CSUM_W = 16, ACC_W = 32, and the 16-bit one's-complement fold function.
REQ-032 Sub-module checksum_lane_sum (combinational: data + keep -> masked lane_sum) SHALL be instantiated once.

Verification
REQ-033 DATA_W=32: beats 0x0001F203, 0xF4F5F6F7 (last, keep 0xF) -> o_checksum 0x220D, o_valid two cycles after last beat.
REQ-034 Single beat 0xABCDEF01, keep 0x8, last -> o_checksum 0x54FF.
REQ-035 Single beat 0x00000000, keep 0xF, last -> 0xFFFF; i_ready held low 3 cycles -> o_valid and o_checksum stable, o_ready 0 throughout.
REQ-036 i_clear asserted after first of three beats -> no o_valid; next packet 0x0001F203/0xF4F5F6F7 still yields 0x220D.
REQ-037 CHECKSUM_SEED_EN defined, i_seed 0x1234, single beat 0x00000000 last -> 0xEDCB.
REQ-038 DATA_W=64: one beat 0x0001F203F4F5F6F7 last keep 0xFF -> 0x220D; 1000 beats of 0xFFFFFFFF -> 0x0000 with no overflow.
